mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/mc_outdec.sv | 62 ++++++
 rtl/mc_controller.sv | 76 +++++++
 tb/tb_mc_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state codes, opcodes, ALU op encodings and control word shared by the multicycle controller and datapath.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       alusrca;
        logic       regdst;
        logic       memtoreg;
        logic       illegal_op;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// mc_outdec: combinational state-to-control-word decode for the multicycle controller.
module mc_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.alusrcb = 2'b01;
                o_ctrl.aluop   = ALUOP_ADD;
                o_ctrl.irwrite = i_mem_ready;
                o_ctrl.pcwrite = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alusrcb    = 2'b11;
                o_ctrl.aluop      = ALUOP_ADD;
                o_ctrl.illegal_op = !op_legal(i_op);
            end
            S_MEMADR, S_ADDIEX: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = 2'b10;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: o_ctrl.iord = 1'b1;
            S_MEMWB: begin
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord     = 1'b1;
                o_ctrl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.aluop   = ALUOP_SUB;
                o_ctrl.pcsrc   = 2'b01;
                o_ctrl.branch  = 1'b1;
            end
            S_ADDIWB: o_ctrl.regwrite = 1'b1;
            S_JUMP: begin
                o_ctrl.pcsrc   = 2'b10;
                o_ctrl.pcwrite = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS Moore control FSM with shared-memory wait states.
module mc_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       illegal_op
);

    state_t r_state;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else begin
            case (r_state)
                S_IDLE:    r_state <= S_FETCH;
                S_FETCH:   if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LB, OP_SB: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECUTE;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (op == OP_SB) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
                S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
                S_EXECUTE: r_state <= S_ALUWB;
                S_ADDIEX:  r_state <= S_ADDIWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    mc_outdec u_outdec (
        .i_state     (r_state),
        .i_op        (op),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Branch resolves against the live zero flag so a taken beq updates PC this cycle.
    assign pcen       = w_ctrl.pcwrite | (w_ctrl.branch & zero);
    assign irwrite    = w_ctrl.irwrite;
    assign regwrite   = w_ctrl.regwrite;
    assign memwrite   = w_ctrl.memwrite;
    assign iord       = w_ctrl.iord;
    assign alusrca    = w_ctrl.alusrca;
    assign regdst     = w_ctrl.regdst;
    assign memtoreg   = w_ctrl.memtoreg;
    assign alusrcb    = w_ctrl.alusrcb;
    assign pcsrc      = w_ctrl.pcsrc;
    assign aluop      = w_ctrl.aluop;
    assign illegal_op = w_ctrl.illegal_op;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scenario and randomized checks of mc_controller against an instruction-path reference model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         st;
        logic [1:0] aluop, pcsrc, alusrcb;
        logic       pcen, regwrite, iord, alusrca, regdst, memtoreg, ill;
    } smp_t;
    smp_t smp[$];

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Expected {pcen, irwrite, regwrite, memwrite} for a state code of the instruction path.
    function automatic logic [3:0] exp_we(input int s, input logic rdy, input logic z);
        case (s)
            1:         return {rdy, rdy, 2'b00};
            5, 8, 11:  return 4'b0010;
            6:         return 4'b0001;
            9:         return {z, 3'b000};
            12:        return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle; wf/wm are mem_ready=0 cycles in FETCH and MEMRD/MEMWR.
    task automatic exec_instr(input logic [5:0] o, input logic z, input int wf, input int wm);
        int path[$];
        int w;
        logic rdy, ill_exp;
        logic [3:0] we_got, we_exp;
        smp_t t;
        smp.delete();
        case (o)
            6'b100000: path = {1, 2, 3, 4, 5};
            6'b101000: path = {1, 2, 3, 6};
            6'b000000: path = {1, 2, 7, 8};
            6'b000100: path = {1, 2, 9};
            6'b001000: path = {1, 2, 10, 11};
            6'b000010: path = {1, 2, 12};
            default:   path = {1, 2};
        endcase
        foreach (path[i]) begin
            w = (path[i] == 1) ? wf : (path[i] == 4 || path[i] == 6) ? wm : 0;
            for (int k = 0; k <= w; k++) begin
                rdy = (path[i] == 1 || path[i] == 4 || path[i] == 6) ? (k == w) : 1'($urandom_range(0, 1));
                op = o; zero = z; mem_ready = rdy;
                #1;
                n_checks++;
                if (state !== 4'(path[i])) $display("FAIL state_seq op=%b step=%0d got %0d want %0d", o, i, state, path[i]);
                else n_pass++;
                we_exp = exp_we(path[i], rdy, z);
                we_got = {pcen, irwrite, regwrite, memwrite};
                n_checks++;
                if (we_got !== we_exp) $display("FAIL write_en op=%b state=%0d got %b want %b", o, path[i], we_got, we_exp);
                else n_pass++;
                ill_exp = (path[i] == 2 && path.size() == 2);
                n_checks++;
                if (illegal_op !== ill_exp) $display("FAIL illegal_op op=%b state=%0d got %b want %b", o, path[i], illegal_op, ill_exp);
                else n_pass++;
                t.st = int'(state); t.aluop = aluop; t.pcsrc = pcsrc; t.alusrcb = alusrcb; t.pcen = pcen;
                t.regwrite = regwrite; t.iord = iord; t.alusrca = alusrca; t.regdst = regdst;
                t.memtoreg = memtoreg; t.ill = illegal_op;
                smp.push_back(t);
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (state !== 4'd1) $display("FAIL latency_return op=%b got state %0d want 1", o, state);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state);
            else n_pass++;
            n_checks++;
            if ({pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, alusrcb, pcsrc, aluop, illegal_op} !== 15'd0)
                $display("FAIL reset_outputs got nonzero want all 0");
            else n_pass++;
        end
        reset_n = 1'b1; #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL release_idle got %0d want 0", state);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 4'd1) $display("FAIL release_fetch got %0d want 1", state);
        else n_pass++;
        n_checks++;
        if (irwrite !== 1'b1) $display("FAIL first_irwrite got %b want 1", irwrite);
        else n_pass++;
    endtask

    task automatic test_rtype();
        exec_instr(6'b000000, 1'b0, 0, 0);
        n_checks++;
        if (smp[2].aluop !== 2'b10 || smp[2].alusrca !== 1'b1) $display("FAIL rtype_exec aluop=%b alusrca=%b want 10/1", smp[2].aluop, smp[2].alusrca);
        else n_pass++;
        n_checks++;
        if (smp[3].regwrite !== 1'b1 || smp[3].regdst !== 1'b1) $display("FAIL rtype_wb regwrite=%b regdst=%b want 1/1", smp[3].regwrite, smp[3].regdst);
        else n_pass++;
    endtask

    task automatic test_lb_wait();
        exec_instr(6'b100000, 1'b0, 0, 2);
        n_checks++;
        if (smp[2].alusrcb !== 2'b10 || smp[2].alusrca !== 1'b1) $display("FAIL lb_memadr alusrcb=%b alusrca=%b want 10/1", smp[2].alusrcb, smp[2].alusrca);
        else n_pass++;
        for (int i = 3; i < 6; i++) begin
            n_checks++;
            if (smp[i].iord !== 1'b1) $display("FAIL lb_memrd_iord cycle=%0d got %b want 1", i, smp[i].iord);
            else n_pass++;
        end
        n_checks++;
        if (smp[6].regwrite !== 1'b1 || smp[6].memtoreg !== 1'b1 || smp[6].regdst !== 1'b0)
            $display("FAIL lb_memwb regwrite=%b memtoreg=%b regdst=%b want 1/1/0", smp[6].regwrite, smp[6].memtoreg, smp[6].regdst);
        else n_pass++;
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            exec_instr(6'b000100, 1'(z), 0, 0);
            n_checks++;
            if (smp[2].pcen !== 1'(z)) $display("FAIL beq_pcen zero=%0d got %b want %0d", z, smp[2].pcen, z);
            else n_pass++;
            n_checks++;
            if (smp[2].pcsrc !== 2'b01 || smp[2].aluop !== 2'b01) $display("FAIL beq_sel zero=%0d pcsrc=%b aluop=%b want 01/01", z, smp[2].pcsrc, smp[2].aluop);
            else n_pass++;
        end
    endtask

    task automatic test_illegal();
        exec_instr(6'b111111, 1'b0, 0, 0);
        n_checks++;
        if (smp[1].ill !== 1'b1 || smp[0].ill !== 1'b0) $display("FAIL illegal_pulse decode=%b fetch=%b want 1/0", smp[1].ill, smp[0].ill);
        else n_pass++;
    endtask

    task automatic test_jump_fetch_wait();
        exec_instr(6'b000010, 1'b0, 3, 0);
        n_checks++;
        if (smp[5].pcsrc !== 2'b10 || smp[5].pcen !== 1'b1) $display("FAIL jump pcsrc=%b pcen=%b want 10/1", smp[5].pcsrc, smp[5].pcen);
        else n_pass++;
    endtask

    task automatic test_sb_reset();
        op = 6'b101000; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0; #1;
        n_checks++;
        if (state !== 4'd6 || memwrite !== 1'b1) $display("FAIL sb_memwr state=%0d memwrite=%b want 6/1", state, memwrite);
        else n_pass++;
        reset_n = 1'b0; #1;
        n_checks++;
        if (memwrite !== 1'b0 || state !== 4'd0 || {pcen, irwrite, regwrite} !== 3'b000)
            $display("FAIL sb_async_reset state=%0d memwrite=%b want 0/0", state, memwrite);
        else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1; #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL sb_release_idle got %0d want 0", state);
        else n_pass++;
        @(posedge clk); #1;
        mem_ready = 1'b1; #1;
        n_checks++;
        if (state !== 4'd1) $display("FAIL sb_release_fetch got %0d want 1", state);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] o;
        ops = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        repeat (40) begin
            o = ops[$urandom_range(0, 6)];
            if (o == 6'b111111) o = 6'($urandom);
            exec_instr(o, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lb_wait();
        test_beq();
        test_illegal();
        test_jump_fetch_wait();
        test_sb_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
